// File: rtl/aes_enc_iterative.sv
// Iterative AES encryption core, one round per clock, AES-128 or AES-256 chosen per block.
// The round key is expanded on the fly from a 256-bit key window.
module aes_enc_iterative #(
   parameter int unsigned SUPPORT_256 = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         key_len,
   input  logic [127:0] plain_text,
   input  logic [255:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] cipher_text,
   output logic         busy
);

   localparam logic HasAes256 = (SUPPORT_256 != 0);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_e         st_q, st_d;
   logic [127:0]   state_q, state_d;
   logic [255:0]   kwin_q, kwin_d;
   logic [3:0]     rnd_q, rnd_d;
   logic           mode_q, mode_d;

   logic           mode;
   logic [3:0]     nr;
   logic           last_rnd;
   logic [31:0]    ks_sub, temp, nw0, nw1, nw2, nw3;
   logic [7:0]     rc;
   logic           key_first;
   logic [127:0]   rk, sb, sr, mc;

   assign mode     = mode_q & HasAes256;
   assign nr       = mode ? 4'd14 : 4'd10;
   assign last_rnd = (rnd_q == nr);

   // AES-256 chains from the newest word of the window, AES-128 from the last word of the key.
   assign ks_sub    = sub_word(mode ? kwin_q[31:0] : kwin_q[159:128]);
   assign rc        = rcon(mode ? {1'b0, rnd_q[3:1]} : rnd_q);
   assign temp      = (!mode || !rnd_q[0]) ? ({ks_sub[23:0], ks_sub[31:24]} ^ {rc, 24'h0})
                                           : ks_sub;
   assign nw0       = kwin_q[255:224] ^ temp;
   assign nw1       = kwin_q[223:192] ^ nw0;
   assign nw2       = kwin_q[191:160] ^ nw1;
   assign nw3       = kwin_q[159:128] ^ nw2;
   assign key_first = mode && (rnd_q == 4'd1);
   assign rk        = key_first ? kwin_q[127:0] : {nw0, nw1, nw2, nw3};

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   always_comb begin
      st_d        = st_q;
      state_d     = state_q;
      kwin_d      = kwin_q;
      rnd_d       = rnd_q;
      mode_d      = mode_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      cipher_text = '0;
      case (st_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = plain_text ^ key[255:128];
               kwin_d  = key;
               mode_d  = key_len & HasAes256;
               rnd_d   = 4'd1;
               st_d    = StRound;
            end
         end
         StRound: begin
            busy    = 1'b1;
            state_d = (last_rnd ? sr : mc) ^ rk;
            if (mode) begin
               if (!key_first) kwin_d = {kwin_q[127:0], nw0, nw1, nw2, nw3};
            end else begin
               kwin_d = {nw0, nw1, nw2, nw3, kwin_q[127:0]};
            end
            rnd_d = rnd_q + 4'd1;
            if (last_rnd) st_d = StDone;
         end
         StDone: begin
            busy        = 1'b1;
            out_valid   = 1'b1;
            cipher_text = state_q;
            if (out_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= StIdle;
         state_q <= '0;
         kwin_q  <= '0;
         rnd_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         kwin_q  <= kwin_d;
         rnd_q   <= rnd_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_aes_enc_iterative.sv
// Scoreboard bench for aes_enc_iterative: known-answer vectors, backpressure, random traffic
// against a table-driven FIPS-197 model, async reset mid-block, and a SUPPORT_256 = 0 instance.
module tb_aes_enc_iterative;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, key_len, out_valid, out_ready, busy;
   logic [127:0] plain_text, cipher_text;
   logic [255:0] key;

   logic         i0_valid, i0_ready, k0_len, o0_valid, o0_ready, busy0;
   logic [127:0] pt0, ct0;
   logic [255:0] key0;

   aes_enc_iterative #(.SUPPORT_256(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .key_len(key_len),
      .plain_text(plain_text), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .cipher_text(cipher_text), .busy(busy)
   );

   aes_enc_iterative #(.SUPPORT_256(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(i0_valid), .in_ready(i0_ready), .key_len(k0_len),
      .plain_text(pt0), .key(key0), .out_valid(o0_valid), .out_ready(o0_ready),
      .cipher_text(ct0), .busy(busy0)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] ct;
      int           c0;
      int           nr;
   } exp_t;
   exp_t q[$];

   logic [7:0] sbox_t [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // Textbook FIPS-197 cipher: full word-array key expansion, byte-array state.
   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] k,
                                            input bit is256);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      int           nk, nr;
      nk = is256 ? 8 : 4;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int j = 1; j < i / nk; j++) rc = xt(rc);
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
         end else if (nk == 8 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: compare on first presentation, then demand stability until the handshake.
   bit           seen = 0, hs_prev = 0;
   logic [127:0] held;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen    = 0;
            hs_prev = 0;
         end else begin
            if (hs_prev) begin
               chki("in_ready after handshake", int'(in_ready), 1);
               hs_prev = 0;
            end
            if (out_valid) begin
               if (!seen) begin
                  if (q.size() == 0) fail_now("unexpected out_valid");
                  else begin
                     chk("cipher_text", cipher_text, q[0].ct);
                     chki("latency", cyc - q[0].c0, q[0].nr);
                  end
                  seen = 1;
                  held = cipher_text;
               end else begin
                  chk("held cipher_text", cipher_text, held);
                  chki("in_ready in DONE", int'(in_ready), 0);
               end
               if (out_ready) begin
                  if (q.size() > 0) void'(q.pop_front());
                  seen    = 0;
                  hs_prev = 1;
               end
            end
         end
      end
   end

   task automatic send_blk(input logic [127:0] pt, input logic [255:0] k, input logic len,
                           input logic [127:0] exp);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) fail_now("wait in_ready");
      else begin
         in_valid   = 1'b1;
         plain_text = pt;
         key        = k;
         key_len    = len;
         q.push_back('{ct: exp, c0: cyc + 1, nr: (len ? 14 : 10)});
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         fail_now("drain timeout");
         q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_rand(input int ncyc, input int p_valid, input int p_ready);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         in_valid   = ($urandom_range(99) < p_valid);
         out_ready  = ($urandom_range(99) < p_ready);
         plain_text = r128();
         key        = {r128(), r128()};
         key_len    = $urandom_range(1);
         if (in_valid && in_ready)
            q.push_back('{ct: ref_enc(plain_text, key, key_len), c0: cyc + 1,
                          nr: (key_len ? 14 : 10)});
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic run_dut0(input logic [127:0] pt, input logic [255:0] k, input logic [127:0] exp);
      int c0, n;
      @(posedge clk); #1;
      chki("dut0 in_ready", int'(i0_ready), 1);
      i0_valid = 1'b1;
      pt0      = pt;
      key0     = k;
      k0_len   = 1'b1;
      c0       = cyc + 1;
      @(posedge clk); #1;
      i0_valid = 1'b0;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (o0_valid) break;
         n++;
      end
      if (!o0_valid) fail_now("dut0 out_valid");
      else begin
         chk("dut0 cipher_text", ct0, exp);
         chki("dut0 latency", cyc - c0, 10);
      end
   endtask

   localparam logic [255:0] Key256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] Pt2 = 128'h00112233445566778899aabbccddeeff;

   initial begin
      logic [127:0] pt;
      logic [255:0] k;
      int           n;
      rst_n = 1'b0;
      in_valid = 1'b0; key_len = 1'b0; plain_text = '0; key = '0; out_ready = 1'b0;
      i0_valid = 1'b0; k0_len = 1'b0; pt0 = '0; key0 = '0; o0_ready = 1'b1;
      #12;
      chki("reset in_ready", int'(in_ready), 1);
      chki("reset out_valid", int'(out_valid), 0);
      chki("reset busy", int'(busy), 0);
      chk("reset cipher_text", cipher_text, '0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      send_blk(128'h3243f6a8885a308d313198a2e0370734,
               {128'h2b7e151628aed2a6abf7158809cf4f3c, r128()}, 1'b0,
               128'h3925841d02dc09fbdc118597196a0b32);
      drain();
      send_blk(Pt2, {128'h000102030405060708090a0b0c0d0e0f, r128()}, 1'b0,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      drain();
      send_blk(Pt2, Key256, 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089);
      drain();

      // SUPPORT_256 = 0 ignores key_len and runs AES-128 on key[255:128].
      run_dut0(Pt2, Key256, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      pt = r128();
      k  = {r128(), r128()};
      run_dut0(pt, k, ref_enc(pt, k, 1'b0));

      // Backpressure: output held 20 cycles while in_valid pulses must be ignored.
      out_ready = 1'b0;
      pt = r128();
      k  = {r128(), r128()};
      send_blk(pt, k, 1'b1, ref_enc(pt, k, 1'b1));
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) fail_now("backpressure out_valid");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         in_valid   = $urandom_range(1);
         plain_text = r128();
         key        = {r128(), r128()};
         key_len    = $urandom_range(1);
      end
      chki("busy in DONE", int'(busy), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Back-to-back: AES-128 then AES-256.
      pt = r128();
      k  = {r128(), r128()};
      send_blk(pt, k, 1'b0, ref_enc(pt, k, 1'b0));
      pt = r128();
      k  = {r128(), r128()};
      send_blk(pt, k, 1'b1, ref_enc(pt, k, 1'b1));
      drain();

      // Random traffic with inputs re-randomised every cycle while blocks are in flight.
      send_rand(3000, 40, 70);
      drain();

      // Asynchronous reset mid-block, checked before any clock edge.
      send_blk(128'h3243f6a8885a308d313198a2e0370734,
               {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
               128'h3925841d02dc09fbdc118597196a0b32);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chki("async reset out_valid", int'(out_valid), 0);
      chki("async reset in_ready", int'(in_ready), 1);
      chki("async reset busy", int'(busy), 0);
      chk("async reset cipher_text", cipher_text, '0);
      q.delete();
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_blk(Pt2, Key256, 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089);
      drain();
      repeat (20) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_enc_iterative.md
Name: aes_enc_iterative

Overview:
- Iterative, round-per-cycle AES encryption core; runtime-selectable AES-128 or AES-256.
- Successor to the fully unrolled combinational AES-128 encryption datapath. Trades throughput for area: one round datapath and on-the-fly key expansion.
- Adds valid/ready handshakes on input and output, so it plugs into the streaming crypto path.

Parameters:
- SUPPORT_256, 1, 1 = AES-256 datapath present and key_len honoured; 0 = key_len ignored, always AES-128.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plain_text/key/key_len valid
- in_ready  output  1  core idle, can accept a block
- key_len  input  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled only at accept
- plain_text  input  128  block to encrypt, byte 0 = bits [127:120]
- key  input  256  cipher key; AES-128 uses key[255:128], key[127:0] ignored
- out_valid  output  1  cipher_text valid
- out_ready  input  1  downstream accepts cipher_text
- cipher_text  output  128  encrypted block
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (rst_n low, async) state:
  - FSM = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - cipher_text, state register, key window, round counter, mode all reset to 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready at edge E0:
    - state <= plain_text ^ first round key (key[255:128]).
    - kwin <= key; mode <= key_len & SUPPORT_256; rnd <= 1; go to ROUND.
- ROUND:
  - in_ready = 0.
  - Each edge applies one round to the state register:
    - Rounds 1..Nr-1: SubBytes, ShiftRows, MixColumns, AddRoundKey.
    - Round Nr: same without MixColumns.
  - Nr = 10 (mode 0) or 14 (mode 1).
  - rnd increments each edge. After the round-Nr edge (E0+Nr), go to DONE.
- Latency: out_valid first high in the cycle after edge E0+Nr, i.e. Nr cycles after the accept edge.
- Key expansion, AES-128:
  - Round key r = f(round key r-1, Rcon[r]).
  - f is the standard RotWord/SubWord/Rcon word chain.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - kwin[255:128] holds the current key.
- Key expansion, AES-256:
  - kwin holds words w[4r-4..4r+3].
  - Round 1 key = kwin[127:0], with no generation step.
  - Round r >= 2 generates words w[4r..4r+3] from kwin:
    - temp = SubWord(RotWord(w[4r-1])) ^ Rcon[r/2] when r is even.
    - temp = SubWord(w[4r-1]) when r is odd.
    - Rcon here is 01..40.
  - Then kwin <= {kwin[127:0], new words}.
- DONE:
  - out_valid = 1; cipher_text = state register.
  - Output is held stable until out_valid && out_ready; then go to IDLE.
  - Backpressure is unbounded; no data loss.
  - in_ready stays 0 in DONE, so the next accept is no earlier than the cycle after the output handshake.
- Input sampling: key_len, key and plain_text changes after accept have no effect on the block in flight.
- Reset mid-operation: block abandoned, all outputs go to their reset values immediately (async), no spurious out_valid.
- With SUPPORT_256 = 0, the AES-256 key logic is not instantiated and mode is forced to 0.
- S-box: combinational. 16 datapath S-boxes plus 4 key-schedule S-boxes, shared between both modes.

Test Plan:
- AES-128 vector: key 2b7e151628aed2a6abf7158809cf4f3c (in key[255:128]), pt 3243f6a8885a308d313198a2e0370734, out_ready = 1.
  - Required: cipher_text 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after accept.
- AES-128 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 vector: key_len = 1, key 000102...1e1f, pt 00112233445566778899aabbccddeeff.
  - Required: 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
  - Repeat with SUPPORT_256 = 0: result equals the AES-128 encryption under key[255:128], 10 cycles.
- Backpressure and stability:
  - Hold out_ready = 0 for 20 cycles after out_valid: cipher_text stable, in_ready = 0, in_valid pulses ignored.
  - Release out_ready: one-cycle handshake, in_ready = 1 on the next cycle.
  - Back-to-back AES-128 then AES-256 blocks: both correct, with mode switching cleanly.
- Input change mid-block: randomise key/pt/key_len every cycle during ROUND; result still matches the vector captured at accept.
- Reset mid-block: deassert rst_n at round 5 (asynchronously).
  - Outputs go to 0 and FSM to IDLE without a clock edge.
  - After release, a fresh block encrypts correctly.
